// File: rtl/escalonador_de_leitura_pkg.sv
// Shared definitions for the sensor read scheduler: requester count, state
// encoding, default timing constants and the round-robin winner search.
package escalonador_de_leitura_pkg;

    localparam int NUM_REQ   = 4;
    localparam int REQ_IDX_W = 2;

    localparam int DEF_CLK_HZ        = 50_000_000;
    localparam int DEF_TICK_HZ       = 1_000_000;
    localparam int DEF_GUARD_TICKS   = 2_000_000;
    localparam int DEF_TIMEOUT_TICKS = 30_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GUARD = 2'd3
    } estado_t;

    // Scans farthest offset first so the requester closest to ptr overwrites last.
    function automatic logic [REQ_IDX_W-1:0] rr_winner(
        input logic [NUM_REQ-1:0]   req_vec,
        input logic [REQ_IDX_W-1:0] ptr
    );
        logic [REQ_IDX_W-1:0] idx;
        rr_winner = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + REQ_IDX_W'(k);
            if (req_vec[idx]) rr_winner = idx;
        end
    endfunction

endpackage

// File: rtl/escalonador_de_leitura_tick.sv
// Free-running clock-enable generator: one-cycle tick every DIV clocks.
module gerador_de_tick #(
    parameter int DIV = 50
) (
    input  logic clock_SYS,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign tick = (count_reg == CNT_W'(DIV - 1));

    always_comb begin
        count_next = tick ? '0 : count_reg + 1'b1;
    end

    always_ff @(posedge clock_SYS) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/escalonador_de_leitura.sv
// Round-robin arbiter giving four requesters exclusive, guarded and
// time-limited access to one shared sensor engine.
module escalonador_de_leitura
    import escalonador_de_leitura_pkg::*;
#(
    parameter int CLK_HZ        = DEF_CLK_HZ,
    parameter int TICK_HZ       = DEF_TICK_HZ,
    parameter int GUARD_TICKS   = DEF_GUARD_TICKS,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic               clock_SYS,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] ack,
    output logic               ack_err,
    output logic               engine_start,
    input  logic               engine_done,
    input  logic               engine_error,
    output logic               tick,
    output logic               busy
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int GD_W = $clog2(GUARD_TICKS + 1);

    estado_t              state_reg,   state_next;
    logic [REQ_IDX_W-1:0] ptr_reg,     ptr_next;
    logic [NUM_REQ-1:0]   grant_reg,   grant_next;
    logic [TO_W-1:0]      timeout_reg, timeout_next;
    logic [GD_W-1:0]      guard_reg,   guard_next;

    logic [REQ_IDX_W-1:0] winner;
    logic [NUM_REQ-1:0]   winner_onehot;
    logic                 timed_out;

    gerador_de_tick #(.DIV(DIV)) u_tick (
        .clock_SYS (clock_SYS),
        .reset     (reset),
        .tick      (tick)
    );

    assign winner = rr_winner(req, ptr_reg);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign winner_onehot[gi] = (winner == REQ_IDX_W'(gi));
    end

    assign timed_out = (timeout_reg == TO_W'(TIMEOUT_TICKS));
    assign grant     = grant_reg;
    assign busy      = (state_reg != ST_IDLE);

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        grant_next   = grant_reg;
        timeout_next = timeout_reg;
        guard_next   = guard_reg;
        ack          = '0;
        ack_err      = 1'b0;
        engine_start = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    grant_next = winner_onehot;
                    ptr_next   = winner + 1'b1;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                engine_start = 1'b1;
                timeout_next = '0;
                state_next   = ST_BUSY;
            end
            ST_BUSY: begin
                // A successful completion outranks a simultaneous error or timeout.
                if (engine_done || engine_error || timed_out) begin
                    ack        = grant_reg;
                    ack_err    = !engine_done;
                    grant_next = '0;
                    guard_next = '0;
                    state_next = ST_GUARD;
                end else if (tick) begin
                    timeout_next = timeout_reg + 1'b1;
                end
            end
            ST_GUARD: begin
                if (guard_reg == GD_W'(GUARD_TICKS)) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    guard_next = guard_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // An access interrupted by reset must never report completion.
        if (reset) begin
            ack          = '0;
            ack_err      = 1'b0;
            engine_start = 1'b0;
        end
    end

    always_ff @(posedge clock_SYS) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= '0;
            grant_reg   <= '0;
            timeout_reg <= '0;
            guard_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            grant_reg   <= grant_next;
            timeout_reg <= timeout_next;
            guard_reg   <= guard_next;
        end
    end

endmodule
